// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register.
// Big-endian byte/half/word loads and stores against a word-organised RAM.
module mem_wb_stage #(
  parameter int DEPTH = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [31:0] PCAddResult4,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [1:0]  MemToReg,
  input  logic        RegWrite,
  input  logic [4:0]  WriteReg,
  output logic [31:0] WB_ALUResult,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_PCAddResult4,
  output logic [1:0]  WB_MemToReg,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_WriteReg,
  output logic        WB_Misaligned
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [4:0]    bpos;
  logic          is_byte;
  logic          is_half;
  logic          misaligned;
  logic          store_en;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic [31:0]   load_ext;
  logic [31:0]   load_data;
  logic [7:0]    lane8;
  logic [15:0]   lane16;
  logic          unused_addr;

  assign idx     = ALUResult[AW+1:2];
  assign off     = ALUResult[1:0];
  assign unused_addr = ^ALUResult[31:AW+2];
  // Lane 0 sits in the top byte, so the bit offset counts down.
  assign bpos    = {~off, 3'b000};
  assign is_byte = (MemSize == 2'b10);
  assign is_half = (MemSize == 2'b01);
  assign rd_word = mem[idx];
  assign lane8   = rd_word[bpos +: 8];
  assign lane16  = off[1] ? rd_word[15:0] : rd_word[31:16];

  always_comb begin
    misaligned = 1'b0;
    if (MemRead || MemWrite) begin
      unique case (1'b1)
        is_byte: misaligned = 1'b0;
        is_half: misaligned = off[0];
        default: misaligned = (off != 2'b00);
      endcase
    end
  end

  always_comb begin
    load_ext = rd_word;
    wr_word  = rd_word;
    unique case (1'b1)
      is_byte: begin
        load_ext = {{24{MemSigned & lane8[7]}}, lane8};
        wr_word[bpos +: 8] = WriteData[7:0];
      end
      is_half: begin
        load_ext = {{16{MemSigned & lane16[15]}}, lane16};
        if (off[1]) wr_word[15:0]  = WriteData[15:0];
        else        wr_word[31:16] = WriteData[15:0];
      end
      default: begin
        load_ext = rd_word;
        wr_word  = WriteData;
      end
    endcase
  end

  assign load_data = (MemRead && !MemWrite && !misaligned)
                   ? load_ext : 32'd0;
  assign store_en  = MemWrite && !misaligned
                   && !Stall && !Flush && !Reset;

  always_ff @(posedge Clk) begin
    if (store_en) mem[idx] <= wr_word;
  end

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      WB_ALUResult    <= 32'd0;
      WB_ReadData     <= 32'd0;
      WB_PCAddResult4 <= 32'd0;
      WB_MemToReg     <= 2'd0;
      WB_RegWrite     <= 1'b0;
      WB_WriteReg     <= 5'd0;
      WB_Misaligned   <= 1'b0;
    end else if (!Stall) begin
      WB_ALUResult    <= ALUResult;
      WB_ReadData     <= load_data;
      WB_PCAddResult4 <= PCAddResult4;
      WB_MemToReg     <= MemToReg;
      WB_RegWrite     <= RegWrite && !misaligned;
      WB_WriteReg     <= WriteReg;
      WB_Misaligned   <= misaligned;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: vector table plus stall/flush sequences,
// expected WB values queued at drive time and compared after the edge.
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush;
  logic [31:0] ALUResult, WriteData, PCAddResult4;
  logic        MemRead, MemWrite, MemSigned, RegWrite;
  logic [1:0]  MemSize, MemToReg;
  logic [4:0]  WriteReg;
  logic [31:0] WB_ALUResult, WB_ReadData, WB_PCAddResult4;
  logic [1:0]  WB_MemToReg;
  logic        WB_RegWrite, WB_Misaligned;
  logic [4:0]  WB_WriteReg;

  always #5 Clk = ~Clk;

  mem_wb_stage #(.DEPTH(1024)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .ALUResult(ALUResult), .WriteData(WriteData),
    .PCAddResult4(PCAddResult4), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WB_ALUResult(WB_ALUResult), .WB_ReadData(WB_ReadData),
    .WB_PCAddResult4(WB_PCAddResult4), .WB_MemToReg(WB_MemToReg),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .WB_Misaligned(WB_Misaligned)
  );

  typedef struct {
    logic [31:0] addr, wdata, pc4;
    logic        mr, mw, sgn, rw, stall, flush;
    logic [1:0]  size, m2r;
    logic [4:0]  wreg;
    logic [31:0] e_alu, e_rd, e_pc4;
    logic [1:0]  e_m2r;
    logic        e_rw, e_mis;
    logic [4:0]  e_wreg;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  vec_t  tbl[$];
  string names[$];
  vec_t  sb[$];
  vec_t  last;

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic vec_t op(
    logic [31:0] addr, logic [31:0] wdata, logic mr, logic mw,
    logic [1:0] size, logic sgn, logic [1:0] m2r, logic rw,
    logic [4:0] wreg, logic [31:0] e_rd, logic e_rw, logic e_mis);
    vec_t v;
    v.addr = addr;  v.wdata = wdata; v.pc4 = 32'h0040_0100 + addr;
    v.mr = mr;      v.mw = mw;       v.size = size; v.sgn = sgn;
    v.m2r = m2r;    v.rw = rw;       v.wreg = wreg;
    v.stall = 1'b0; v.flush = 1'b0;
    v.e_alu = addr; v.e_rd = e_rd;   v.e_pc4 = v.pc4;
    v.e_m2r = m2r;  v.e_rw = e_rw;   v.e_wreg = wreg;
    v.e_mis = e_mis;
    return v;
  endfunction

  function automatic vec_t zero_exp(vec_t v);
    vec_t z = v;
    z.e_alu = 0; z.e_rd = 0; z.e_pc4 = 0; z.e_m2r = 0;
    z.e_rw = 0;  z.e_wreg = 0; z.e_mis = 0;
    return z;
  endfunction

  function automatic vec_t hold_exp(vec_t v, vec_t p);
    vec_t h = v;
    h.e_alu = p.e_alu; h.e_rd = p.e_rd; h.e_pc4 = p.e_pc4;
    h.e_m2r = p.e_m2r; h.e_rw = p.e_rw; h.e_wreg = p.e_wreg;
    h.e_mis = p.e_mis;
    return h;
  endfunction

  task automatic drive(vec_t v);
    ALUResult = v.addr; WriteData = v.wdata; PCAddResult4 = v.pc4;
    MemRead = v.mr;     MemWrite = v.mw;     MemSize = v.size;
    MemSigned = v.sgn;  MemToReg = v.m2r;    RegWrite = v.rw;
    WriteReg = v.wreg;  Stall = v.stall;     Flush = v.flush;
  endtask

  task automatic step(string n, vec_t v);
    vec_t e;
    if (v.flush)      e = zero_exp(v);
    else if (v.stall) e = hold_exp(v, last);
    else              e = v;
    drive(v);
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check({n, ".alu"},  WB_ALUResult,    e.e_alu);
    check({n, ".rd"},   WB_ReadData,     e.e_rd);
    check({n, ".pc4"},  WB_PCAddResult4, e.e_pc4);
    check({n, ".m2r"},  32'(WB_MemToReg), 32'(e.e_m2r));
    check({n, ".rw"},   32'(WB_RegWrite), 32'(e.e_rw));
    check({n, ".wreg"}, 32'(WB_WriteReg), 32'(e.e_wreg));
    check({n, ".mis"},  32'(WB_Misaligned), 32'(e.e_mis));
    last = e;
  endtask

  task automatic add(string n, vec_t v);
    names.push_back(n);
    tbl.push_back(v);
  endtask

  initial begin
    vec_t v;
    vec_t idle;
    idle = op(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);
    idle.pc4 = 0; idle.e_pc4 = 0;

    add("lb_s",    op(32'h10, 0, 1, 0, 2'b10, 1, 2'b01, 1, 5'd2,
                      32'hFFFF_FF88, 1, 0));
    add("lbu",     op(32'h13, 0, 1, 0, 2'b10, 0, 2'b01, 1, 5'd3,
                      32'h0000_00BB, 1, 0));
    add("lh_s",    op(32'h12, 0, 1, 0, 2'b01, 1, 2'b01, 1, 5'd4,
                      32'hFFFF_AABB, 1, 0));
    add("lhu",     op(32'h10, 0, 1, 0, 2'b01, 0, 2'b01, 1, 5'd5,
                      32'h0000_8899, 1, 0));
    add("sb",      op(32'h11, 32'h0000_00EE, 0, 1, 2'b10, 0, 2'b00, 0,
                      5'd0, 0, 0, 0));
    add("lw_sb",   op(32'h10, 0, 1, 0, 2'b00, 0, 2'b01, 1, 5'd6,
                      32'h88EE_AABB, 1, 0));
    add("sh",      op(32'h12, 32'hFFFF_1234, 0, 1, 2'b01, 0, 2'b00, 0,
                      5'd0, 0, 0, 0));
    add("lw_sh",   op(32'h10, 0, 1, 0, 2'b00, 0, 2'b01, 1, 5'd7,
                      32'h88EE_1234, 1, 0));
    add("lw_mis",  op(32'h12, 0, 1, 0, 2'b00, 0, 2'b01, 1, 5'd8,
                      0, 0, 1));
    add("sw_mis",  op(32'h11, 32'hCAFE_F00D, 0, 1, 2'b00, 0, 2'b00, 0,
                      5'd0, 0, 0, 1));
    add("lw_keep", op(32'h10, 0, 1, 0, 2'b00, 0, 2'b01, 1, 5'd9,
                      32'h88EE_1234, 1, 0));
    add("lh_mis",  op(32'h13, 0, 1, 0, 2'b01, 1, 2'b01, 1, 5'd10,
                      0, 0, 1));
    add("rdwr",    op(32'h14, 32'h55AA_55AA, 1, 1, 2'b00, 0, 2'b01, 1,
                      5'd11, 0, 1, 0));
    add("lw_rdwr", op(32'h14, 0, 1, 0, 2'b00, 0, 2'b01, 1, 5'd12,
                      32'h55AA_55AA, 1, 0));
    add("sz11",    op(32'h10, 0, 1, 0, 2'b11, 1, 2'b01, 1, 5'd13,
                      32'h88EE_1234, 1, 0));
    add("sz11_mis",op(32'h12, 0, 1, 0, 2'b11, 0, 2'b01, 1, 5'd14,
                      0, 0, 1));
    add("wrap",    op(32'h0000_1010, 0, 1, 0, 2'b00, 0, 2'b01, 1, 5'd15,
                      32'h88EE_1234, 1, 0));
    add("noread",  op(32'h10, 0, 0, 0, 2'b00, 0, 2'b00, 1, 5'd16,
                      0, 1, 0));

    dut.mem[4] = 32'h1122_3344;
    dut.mem[8] = 32'h0;
    dut.mem[9] = 32'h1357_9BDF;

    // Reset while a store to word 4 is presented
    v = op(32'h10, 32'hFFFF_FFFF, 1, 1, 2'b00, 1, 2'b10, 1, 5'd31,
           0, 0, 0);
    drive(v);
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("rst.alu",  WB_ALUResult, 0);
    check("rst.rd",   WB_ReadData, 0);
    check("rst.pc4",  WB_PCAddResult4, 0);
    check("rst.ctl",  {WB_MemToReg, WB_RegWrite, WB_WriteReg,
                       WB_Misaligned}, 0);
    Reset = 1'b0;
    last = zero_exp(idle);
    step("idle", idle);
    step("lw_rst", op(32'h10, 0, 1, 0, 2'b00, 0, 2'b01, 1, 5'd1,
                      32'h1122_3344, 1, 0));
    check("mem_rst", dut.mem[4], 32'h1122_3344);

    dut.mem[4] = 32'h8899_AABB;
    for (int i = 0; i < tbl.size(); i++) step(names[i], tbl[i]);
    check("mem_w4", dut.mem[4], 32'h88EE_1234);

    // Stall a store for three cycles, then release
    v = op(32'h20, 32'hDEAD_BEEF, 0, 1, 2'b00, 0, 2'b00, 0, 5'd0,
           0, 0, 0);
    v.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall", v);
      check("stall_mem", dut.mem[8], 32'h0);
    end
    v.stall = 1'b0;
    step("release", v);
    check("rel_mem", dut.mem[8], 32'hDEAD_BEEF);
    step("lw_rel", op(32'h20, 0, 1, 0, 2'b00, 0, 2'b01, 1, 5'd17,
                      32'hDEAD_BEEF, 1, 0));

    // Flushed store must not reach memory
    v = op(32'h24, 32'h0BAD_BEEF, 0, 1, 2'b00, 0, 2'b00, 0, 5'd0,
           0, 0, 0);
    v.flush = 1'b1;
    step("flush_sw", v);
    check("flush_mem", dut.mem[9], 32'h1357_9BDF);

    // jal link pass-through, then flush+stall bubble
    v = op(32'h0, 0, 0, 0, 2'b00, 0, 2'b10, 1, 5'd31, 0, 1, 0);
    v.pc4 = 32'h0040_0008; v.e_pc4 = 32'h0040_0008;
    step("jal", v);
    v.stall = 1'b1; v.flush = 1'b1;
    step("fl_st", v);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
